fft_sample_loader: RTL and testbench

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

---
 rtl/fft_pkg.sv | 38 +++
 rtl/fft_sample_loader_if.sv | 12 +
 rtl/fft_sample_loader.sv | 88 ++++++++
 tb/tb_fft_sample_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT types, sizes, twiddles and the bit-reversal index helper.
// Used by fft_sample_loader (FFT_BITREV_EN selects DIT input order).
package fft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_PT_DEF   = 16;
  localparam int LOG2_N     = $clog2(N_PT_DEF);

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } ld_state_t;

  // Q15 twiddles W16^k = cos - j*sin, k = 0..7
  localparam sample_t TW_RE [0:7] = '{
    16'sd32767, 16'sd30273, 16'sd23170, 16'sd12539,
    16'sd0, -16'sd12539, -16'sd23170, -16'sd30273
  };
  localparam sample_t TW_IM [0:7] = '{
    16'sd0, -16'sd12539, -16'sd23170, -16'sd30273,
    -16'sd32767, -16'sd30273, -16'sd23170, -16'sd12539
  };

  function automatic int unsigned bitrev(
    input int unsigned k,
    input int unsigned bits
  );
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[bits-1-i] = k[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_loader_if.sv
// Valid/ready sample stream into the FFT sample loader.
// The loader never back-pressures outside reset/clear.
interface fft_sample_loader_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fft_sample_loader.sv
// Double-banked frame collector feeding the FFT x_re_i / valid_i.
// Define FFT_BITREV_EN to store arrival index k at bitrev(k).
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_PT   = N_PT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     in_ready_o,
  input  logic                     clear_i,
  output logic [DATA_W-1:0]        frame_o [0:N_PT-1],
  output logic                     frame_valid_o,
  output logic [$clog2(N_PT):0]    count_o
);

  localparam int IDX_W = $clog2(N_PT);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PT - 1);

  ld_state_t         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] fill_q [0:N_PT-1];
  logic [DATA_W-1:0] fill_d [0:N_PT-1];
  logic [DATA_W-1:0] out_q  [0:N_PT-1];
  logic [DATA_W-1:0] out_d  [0:N_PT-1];
  logic              fv_q, fv_d;
  logic              accept;
  logic              last;
  logic [IDX_W-1:0]  wr_idx;

  assign in_ready_o    = rst_ni & ~clear_i;
  assign accept        = in_valid_i & in_ready_o;
  assign last          = (state_q == FILL) && (count_q == LAST);
  assign frame_o       = out_q;
  assign frame_valid_o = fv_q;
  assign count_o       = count_q;

`ifdef FFT_BITREV_EN
  assign wr_idx = IDX_W'(bitrev(32'(count_q), IDX_W));
`else
  assign wr_idx = count_q[IDX_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fill_d  = fill_q;
    out_d   = out_q;
    fv_d    = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (accept) begin
      fill_d[wr_idx] = in_data_i;
      if (last) begin
        // hand the completed bank over, including this sample
        out_d   = fill_d;
        state_d = IDLE;
        count_d = '0;
        fv_d    = 1'b1;
      end else begin
        state_d = FILL;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      fill_q  <= '{default: '0};
      out_q   <= '{default: '0};
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      fv_q    <= fv_d;
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader (N_PT=16, DATA_W=16).
// Build with +define+FFT_BITREV_EN to check DIT ordering.
module tb_fft_sample_loader;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int NP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic [DW-1:0] frame [0:NP-1];
  logic fv;
  logic [4:0] cnt;

  always #5 clk = ~clk;

  fft_sample_loader_if #(.DATA_W(DW)) bus ();

  fft_sample_loader #(.DATA_W(DW), .N_PT(NP)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (bus.valid),
    .in_data_i     (bus.data),
    .in_ready_o    (bus.ready),
    .clear_i       (clear),
    .frame_o       (frame),
    .frame_valid_o (fv),
    .count_o       (cnt)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc = 0;
  int p_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fv === 1'b1) begin
      pulses <= pulses + 1;
      p_cyc.push_back(cyc);
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int pos(int k);
`ifdef FFT_BITREV_EN
    return int'({k[0], k[1], k[2], k[3]});
`else
    return k;
`endif
  endfunction

  task automatic send(logic [DW-1:0] d);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data  = d;
    clear     = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic chk_frame(string tag, logic [DW-1:0] base,
                           logic [DW-1:0] step);
    for (int k = 0; k < NP; k++)
      check(tag, frame[pos(k)], base + DW'(k) * step);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int n0;
    int bad;
    bus.valid = 1'b0;
    bus.data  = '0;
    #2 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_cnt", cnt, 0);
    check("rst_fv", fv, 0);
    check("rst_rdy", bus.ready, 0);
    check("rst_f0", frame[0], 0);
    check("rst_f15", frame[15], 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rdy_up", bus.ready, 1);

    // single frame
    p0 = pulses;
    for (int i = 0; i < NP; i++) send(DW'(i));
    idle();
    check("s_fv", fv, 1);
    check("s_cnt", cnt, 0);
    chk_frame("s_frame", 16'h0000, 16'h0001);
    idle();
    check("s_fv_drop", fv, 0);
    check("s_pulses", pulses - p0, 1);

    // back-to-back frames
    p0 = pulses;
    n0 = p_cyc.size();
    bad = 0;
    for (int i = 0; i < 2 * NP; i++) begin
      send(16'h0100 + DW'(i));
      if (i >= NP && frame[pos(5)] !== 16'h0105) bad++;
    end
    check("b2b_stable", bad, 0);
    idle();
    check("b2b_fv", fv, 1);
    chk_frame("b2b_frame", 16'h0110, 16'h0001);
    idle();
    check("b2b_pulses", pulses - p0, 2);
    if (p_cyc.size() >= n0 + 2)
      check("b2b_gap", p_cyc[n0+1] - p_cyc[n0], 16);
    else
      check("b2b_gap", p_cyc.size(), n0 + 2);

    // gapped input
    p0 = pulses;
    bad = 0;
    for (int i = 0; i < NP; i++) begin
      if (i % 3 == 1) begin
        idle();
        if (cnt !== 5'(i)) bad++;
      end
      send(16'h2000 + DW'(i * 7));
      if (cnt !== 5'(i)) bad++;
      if (frame[pos(2)] !== 16'h0112) bad++;
    end
    check("gap_cnt", bad, 0);
    idle();
    check("gap_fv", fv, 1);
    chk_frame("gap_frame", 16'h2000, 16'h0007);
    idle();
    check("gap_pulses", pulses - p0, 1);

    // clear after 7 samples
    p0 = pulses;
    for (int i = 0; i < 7; i++) send(16'h4000 + DW'(i));
    idle();
    check("clr_cnt7", cnt, 7);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data  = 16'hDEAD;
    clear     = 1'b1;
    #1 check("clr_rdy", bus.ready, 0);
    idle();
    check("clr_cnt0", cnt, 0);
    check("clr_keep", frame[pos(0)], 16'h2000);
    for (int i = 0; i < NP; i++) send(16'h8000 + DW'(i));
    check("clr_prior", frame[pos(15)], 16'h2069);
    idle();
    check("clr_fv", fv, 1);
    chk_frame("clr_frame", 16'h8000, 16'h0001);
    idle();
    check("clr_pulses", pulses - p0, 1);

    // clear with the 16th sample
    p0 = pulses;
    for (int i = 0; i < NP - 1; i++) send(16'h3000 + DW'(i));
    @(negedge clk);
    bus.valid = 1'b1;
    bus.data  = 16'h300F;
    clear     = 1'b1;
    idle();
    check("cl16_fv", fv, 0);
    check("cl16_cnt", cnt, 0);
    idle();
    check("cl16_pulses", pulses - p0, 0);
    check("cl16_keep", frame[pos(0)], 16'h8000);

    // reset mid-frame
    for (int i = 0; i < 5; i++) send(16'h5000 + DW'(i));
    @(negedge clk);
    bus.valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mrst_cnt", cnt, 0);
    check("mrst_fv", fv, 0);
    check("mrst_rdy", bus.ready, 0);
    bad = 0;
    for (int k = 0; k < NP; k++) if (frame[k] !== '0) bad++;
    check("mrst_frame", bad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) send(DW'(i));
    idle();
    check("post_fv", fv, 1);
    chk_frame("post_frame", 16'h0000, 16'h0001);
`ifdef FFT_BITREV_EN
    check("br_f1", frame[1], 8);
    check("br_f3", frame[3], 12);
`else
    check("br_f1", frame[1], 1);
    check("br_f3", frame[3], 3);
`endif
    check("br_f15", frame[15], 15);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
